// File: rtl/adder_issue_ctrl_if.sv
// adder_issue_ctrl_if
// Bundles the issue controller's operand input port, half_adder FU request
// and response signals, result output port and op counter.
//   master : controller side (drives in_ready, fu_*, out_*, op_count)
//   slave  : tile/environment side (drives operands, FU response, out_ready)
interface adder_issue_ctrl_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;

    logic                 fu_on_off;
    logic [WIDTH-1:0]     fu_a;
    logic [WIDTH-1:0]     fu_b;
    logic [WIDTH-1:0]     fu_c;
    logic                 fu_carry_out;
    logic                 fu_ack;

    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_sum;
    logic                 out_carry;
    logic                 out_timeout;

    logic [CNT_WIDTH-1:0] op_count;

    modport master (
        input  in_valid, in_a, in_b,
        input  fu_c, fu_carry_out, fu_ack,
        input  out_ready,
        output in_ready,
        output fu_on_off, fu_a, fu_b,
        output out_valid, out_sum, out_carry, out_timeout,
        output op_count
    );

    modport slave (
        output in_valid, in_a, in_b,
        output fu_c, fu_carry_out, fu_ack,
        output out_ready,
        input  in_ready,
        input  fu_on_off, fu_a, fu_b,
        input  out_valid, out_sum, out_carry, out_timeout,
        input  op_count
    );
endinterface

// File: rtl/adder_issue_ctrl.sv
// adder_issue_ctrl
// Issue controller in front of the half_adder FU. Accepts an operand pair,
// holds the FU enabled with the operands until fu_ack or a timeout, captures
// {carry, sum} and offers it on the result port. Counts successful ops.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : adder_issue_ctrl_if.master (operand in, FU request/response,
//           result out, op_count)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for an operand pair
// S_WAIT | FU enabled with latched operands, waiting for ack/timeout
// S_DONE | result (or timeout marker) offered until out_ready
module adder_issue_ctrl #(
    parameter int WIDTH     = 16,
    parameter int TIMEOUT   = 15,
    parameter int CNT_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    adder_issue_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT);

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [7:0]           timer;
    logic                 timer_tc;
    logic [WIDTH-1:0]     sum_q;
    logic                 carry_q;
    logic                 timeout_q;
    logic [CNT_WIDTH-1:0] count_q;

    // Down-counter loaded with TIMEOUT on accept; terminal count of 1 marks
    // the last allowed WAIT cycle.
    assign timer_tc = (timer == 8'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.fu_on_off = 1'b0;
        bus.fu_a      = '0;
        bus.fu_b      = '0;
        bus.out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                // Held low while reset is asserted so nothing is offered
                // acceptance that the register block would discard.
                bus.in_ready = ~reset;
                if (bus.in_valid) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                bus.fu_on_off = 1'b1;
                bus.fu_a      = op_a;
                bus.fu_b      = op_b;
                if (bus.fu_ack || timer_tc) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            timer     <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_a  <= bus.in_a;
                        op_b  <= bus.in_b;
                        timer <= TIMER_LOAD;
                    end
                end
                S_WAIT: begin
                    // Ack takes priority so a response on the final allowed
                    // cycle is still delivered as data.
                    if (bus.fu_ack) begin
                        sum_q     <= bus.fu_c;
                        carry_q   <= bus.fu_carry_out;
                        timeout_q <= 1'b0;
                        count_q   <= count_q + 1'b1;
                    end else if (timer_tc) begin
                        sum_q     <= '0;
                        carry_q   <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.out_sum     = sum_q;
    assign bus.out_carry   = carry_q;
    assign bus.out_timeout = timeout_q;
    assign bus.op_count    = count_q;

endmodule

// File: tb/tb_adder_issue_ctrl.sv
// tb_adder_issue_ctrl
// Drives adder_issue_ctrl against a half_adder stub whose ack can be delayed
// a programmable number of WAIT cycles (or withheld). Expected results come
// from plain arithmetic on the operands and the ack delay vs TIMEOUT.
module tb_adder_issue_ctrl;
    localparam int WIDTH     = 16;
    localparam int TIMEOUT   = 4;
    localparam int CNT_WIDTH = 8;

    logic clk = 1'b0;
    logic reset;

    adder_issue_ctrl_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    adder_issue_ctrl #(
        .WIDTH    (WIDTH),
        .TIMEOUT  (TIMEOUT),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // FU stub: combinational adder; ack after ack_delay cycles of on_off.
    // Data is corrupted whenever ack is low so stray sampling shows up.
    int unsigned  ack_delay;
    int unsigned  wait_cnt;
    logic [WIDTH:0] fu_full;

    always @(posedge clk or posedge reset) begin
        if (reset)              wait_cnt <= 0;
        else if (bus.fu_on_off) wait_cnt <= wait_cnt + 1;
        else                    wait_cnt <= 0;
    end

    assign fu_full          = {1'b0, bus.fu_a} + {1'b0, bus.fu_b};
    assign bus.fu_ack       = bus.fu_on_off && (wait_cnt >= ack_delay);
    assign bus.fu_c         = bus.fu_ack ? fu_full[WIDTH-1:0] : ~fu_full[WIDTH-1:0];
    assign bus.fu_carry_out = bus.fu_ack ? fu_full[WIDTH]     : ~fu_full[WIDTH];

    int tests = 0;
    int fails = 0;
    int exp_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and check the result as it appears. Leaves the DUT in DONE.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int unsigned delay);
        int n;
        int lat;
        int on_cycles;
        int exp_lat;
        logic exp_to;
        logic [WIDTH:0] exp_res;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        ack_delay    = delay;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", 32'(n < 50), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("fu_on_first", 32'(bus.fu_on_off), 32'd1);
        check("fu_a_wait", 32'(bus.fu_a), 32'(a));
        check("fu_b_wait", 32'(bus.fu_b), 32'(b));
        check("in_ready_wait_low", 32'(bus.in_ready), 32'd0);
        lat = 0;
        on_cycles = 0;
        while (!bus.out_valid && lat < 300) begin
            if (bus.fu_on_off) on_cycles++;
            tick();
            lat++;
        end
        exp_to  = (delay + 1 > TIMEOUT);
        exp_lat = exp_to ? TIMEOUT : int'(delay) + 1;
        exp_res = exp_to ? '0 : ({1'b0, a} + {1'b0, b});
        if (!exp_to) exp_count = (exp_count + 1) % (1 << CNT_WIDTH);
        check("latency", 32'(lat), 32'(exp_lat));
        check("fu_on_cycles", 32'(on_cycles), 32'(exp_lat));
        check("result", 32'({bus.out_carry, bus.out_sum}), 32'(exp_res));
        check("out_timeout", 32'(bus.out_timeout), 32'(exp_to));
        check("op_count", 32'(bus.op_count), 32'(exp_count));
        check("fu_on_done", 32'(bus.fu_on_off), 32'd0);
        check("fu_a_done", 32'(bus.fu_a), 32'd0);
        check("in_ready_done", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        tick();
        check("out_valid_drop", 32'(bus.out_valid), 32'd0);
        check("in_ready_back", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] held_sum;
        logic [WIDTH-1:0] na;
        logic [WIDTH-1:0] nb;
        logic [WIDTH:0]   nexp;

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.out_ready = 1'b1;
        ack_delay    = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_fu_on", 32'(bus.fu_on_off), 32'd0);
        check("rst_op_count", 32'(bus.op_count), 32'd0);
        check("rst_out_sum", 32'(bus.out_sum), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Basic add and carry cases
        run_op(16'h1234, 16'h5678, 0);
        release_out();
        run_op(16'hFFFF, 16'h0001, 0);
        release_out();
        run_op(16'h8000, 16'h8000, 0);
        release_out();

        // Timeout, then ack exactly on the last allowed cycle, then one late
        run_op(16'hAAAA, 16'h5555, 255);
        release_out();
        run_op(16'hFFF0, 16'h000F, TIMEOUT - 1);
        release_out();
        run_op(16'h0F0F, 16'hF0F0, TIMEOUT);
        release_out();

        // Randomized ops, some timing out
        for (int i = 0; i < 40; i++) begin
            run_op(16'($urandom), 16'($urandom), $urandom_range(0, 5));
            release_out();
        end

        // Backpressure with a new pair waiting upstream
        bus.out_ready = 1'b0;
        run_op(16'hC001, 16'h4FFF, 1);
        held_sum = bus.out_sum;
        na = 16'h2468;
        nb = 16'h1357;
        bus.in_a     = na;
        bus.in_b     = nb;
        bus.in_valid = 1'b1;
        ack_delay    = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_sum_stable", 32'(bus.out_sum), 32'(held_sum));
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
        check("bp_fu_idle", 32'(bus.fu_on_off), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        check("bp_accept_on", 32'(bus.fu_on_off), 32'd1);
        check("bp_accept_a", 32'(bus.fu_a), 32'(na));
        tick();
        nexp = {1'b0, na} + {1'b0, nb};
        exp_count = (exp_count + 1) % (1 << CNT_WIDTH);
        check("bp_new_valid", 32'(bus.out_valid), 32'd1);
        check("bp_new_result", 32'({bus.out_carry, bus.out_sum}), 32'(nexp));
        check("bp_new_count", 32'(bus.op_count), 32'(exp_count));
        release_out();

        // Reset in the middle of WAIT
        bus.in_a     = 16'h7777;
        bus.in_b     = 16'h1111;
        ack_delay    = 255;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("mid_wait_on", 32'(bus.fu_on_off), 32'd1);
        reset = 1'b1;
        #1;
        exp_count = 0;
        check("arst_fu_on", 32'(bus.fu_on_off), 32'd0);
        check("arst_fu_a", 32'(bus.fu_a), 32'd0);
        check("arst_fu_b", 32'(bus.fu_b), 32'd0);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_res", 32'({bus.out_timeout, bus.out_carry, bus.out_sum}), 32'd0);
        check("arst_op_count", 32'(bus.op_count), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd0);
        #3;
        reset = 1'b0;
        #1;
        check("arst_release_ready", 32'(bus.in_ready), 32'd1);

        // Counter wrap: 256 successful ops
        for (int i = 0; i < 256; i++) begin
            run_op(16'($urandom), 16'($urandom), $urandom_range(0, TIMEOUT - 1));
            release_out();
        end
        check("op_count_wrap", 32'(bus.op_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
